// File: rtl/bp_fetch_seq_if.sv
// rtl/bp_fetch_seq_if.sv - fetch request, pre-decode response and flush bundle for bp_fetch_seq
// Ports (slave = sequencer side):
//   i_flush_valid/i_flush_pc          redirect the fetch stream
//   o_req_valid/o_req_addr/i_req_ready fetch request handshake
//   i_pd_valid/i_pd_jmp/i_pd_pc/i_pd_npc pre-decoded memory response
//   o_resp_valid/o_resp_pc/o_resp_drop forwarded or discarded response
//   o_redirect, o_outstanding, o_err_order status
interface bp_fetch_seq_if #(
    parameter int RISCV_ARCH = 64,
    parameter int QDEPTH     = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic                  i_flush_valid;
    logic [RISCV_ARCH-1:0] i_flush_pc;
    logic                  o_req_valid;
    logic [RISCV_ARCH-1:0] o_req_addr;
    logic                  i_req_ready;
    logic                  i_pd_valid;
    logic                  i_pd_jmp;
    logic [RISCV_ARCH-1:0] i_pd_pc;
    logic [RISCV_ARCH-1:0] i_pd_npc;
    logic                  o_resp_valid;
    logic [RISCV_ARCH-1:0] o_resp_pc;
    logic                  o_resp_drop;
    logic                  o_redirect;
    logic [CW-1:0]         o_outstanding;
    logic                  o_err_order;

    modport slave (
        input  i_flush_valid, i_flush_pc, i_req_ready,
        input  i_pd_valid, i_pd_jmp, i_pd_pc, i_pd_npc,
        output o_req_valid, o_req_addr,
        output o_resp_valid, o_resp_pc, o_resp_drop,
        output o_redirect, o_outstanding, o_err_order
    );

    modport master (
        output i_flush_valid, i_flush_pc, i_req_ready,
        output i_pd_valid, i_pd_jmp, i_pd_pc, i_pd_npc,
        input  o_req_valid, o_req_addr,
        input  o_resp_valid, o_resp_pc, o_resp_drop,
        input  o_redirect, o_outstanding, o_err_order
    );
endinterface

// File: rtl/bp_fetch_seq.sv
// rtl/bp_fetch_seq.sv - fetch-address sequencer with in-order outstanding FIFO and jump redirect
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    bp_fetch_seq_if.slave: flush input, fetch request handshake,
//          pre-decoder response input, response/redirect/status outputs
module bp_fetch_seq #(
    parameter int RISCV_ARCH = 64,
    parameter int QDEPTH     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bp_fetch_seq_if.slave     bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [RISCV_ARCH-1:0] req_addr;
    logic [RISCV_ARCH-1:0] fifo [QDEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         discard_cnt;
    logic                  err_order;

    logic                  pop;
    logic                  push;
    logic                  stale;
    logic                  resp_ok;
    logic                  redirect;
    logic                  order_bad;
    logic [RISCV_ARCH-1:0] head;
    logic [RISCV_ARCH-1:0] next_entry;
    logic [RISCV_ARCH-1:0] expected;

    assign pop     = bus.i_pd_valid && (count != '0);
    // A response in a flush cycle belongs to the abandoned stream.
    assign stale   = (discard_cnt != '0) || bus.i_flush_valid;
    assign resp_ok = pop && !stale;

    assign head       = fifo[rd_ptr];
    assign next_entry = fifo[rd_ptr + PW'(1)];
    // The address that will follow the head: the next queued entry, or the
    // not-yet-issued req_addr when the head is the only one in flight.
    assign expected   = (count >= CW'(2)) ? next_entry : req_addr;
    assign redirect   = resp_ok && bus.i_pd_jmp && (bus.i_pd_npc != expected);

    // Masking by redirect keeps the stale req_addr from ever reaching memory.
    assign bus.o_req_valid = (state == RUN) && (count != DEPTH)
                           && !bus.i_flush_valid && !redirect;
    assign push = bus.o_req_valid && bus.i_req_ready;

    assign order_bad = (bus.i_pd_valid && (count == '0))
                     || (resp_ok && (bus.i_pd_pc != head));

    assign bus.o_req_addr    = req_addr;
    assign bus.o_resp_valid  = resp_ok;
    assign bus.o_resp_pc     = resp_ok ? bus.i_pd_pc : '0;
    assign bus.o_resp_drop   = pop && stale;
    assign bus.o_redirect    = redirect;
    assign bus.o_outstanding = count;
    assign bus.o_err_order   = err_order;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            discard_cnt <= '0;
            err_order   <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= req_addr;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            if (bus.i_flush_valid) begin
                state       <= RUN;
                req_addr    <= bus.i_flush_pc;
                discard_cnt <= count - CW'(pop);
            end else if (redirect) begin
                req_addr    <= bus.i_pd_npc;
                discard_cnt <= count - CW'(1);
            end else begin
                if (push) begin
                    req_addr <= req_addr + RISCV_ARCH'(4);
                end
                if (pop && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end

            if (order_bad) begin
                err_order <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bp_fetch_seq.sv
// tb/tb_bp_fetch_seq.sv - self-checking bench for bp_fetch_seq against a queue-based reference model
module tb_bp_fetch_seq;
    localparam int AW = 64;
    localparam int QD = 4;
    localparam int CW = $clog2(QD) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_fetch_seq_if #(.RISCV_ARCH(AW), .QDEPTH(QD)) bus ();

    bp_fetch_seq #(.RISCV_ARCH(AW), .QDEPTH(QD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            stale;
    } ent_t;

    ent_t          q[$];
    bit            m_run;
    logic [AW-1:0] m_pc;
    bit            m_err;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_flush_valid = 1'b0;
        bus.i_flush_pc    = '0;
        bus.i_req_ready   = 1'b0;
        bus.i_pd_valid    = 1'b0;
        bus.i_pd_jmp      = 1'b0;
        bus.i_pd_pc       = '0;
        bus.i_pd_npc      = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_run = 1'b0;
        m_pc  = '0;
        m_err = 1'b0;
        q.delete();
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle,
    // then advance the model at the edge.
    task automatic step(input logic fl, input logic [AW-1:0] fpc, input logic rdy,
                        input logic pv, input logic jmp,
                        input logic [AW-1:0] ppc, input logic [AW-1:0] npc);
        int            cnt;
        bit            pop, stale, e_rv, e_rd, e_req, e_err;
        logic [AW-1:0] exp_next;
        bus.i_flush_valid = fl;
        bus.i_flush_pc    = fpc;
        bus.i_req_ready   = rdy;
        bus.i_pd_valid    = pv;
        bus.i_pd_jmp      = jmp;
        bus.i_pd_pc       = ppc;
        bus.i_pd_npc      = npc;
        @(negedge clk);
        cnt      = q.size();
        pop      = pv && (cnt > 0);
        stale    = pop && (q[0].stale || fl);
        e_rv     = pop && !stale;
        exp_next = (cnt >= 2) ? q[1].addr : m_pc;
        e_rd     = e_rv && jmp && (npc != exp_next);
        e_req    = m_run && (cnt < QD) && !fl && !e_rd;
        e_err    = m_err || (pv && (cnt == 0)) || (e_rv && (ppc != q[0].addr));

        chk("req_valid",   AW'(bus.o_req_valid),   AW'(e_req));
        chk("req_addr",    bus.o_req_addr,         m_pc);
        chk("resp_valid",  AW'(bus.o_resp_valid),  AW'(e_rv));
        chk("resp_pc",     bus.o_resp_pc,          e_rv ? ppc : '0);
        chk("resp_drop",   AW'(bus.o_resp_drop),   AW'(stale));
        chk("redirect",    AW'(bus.o_redirect),    AW'(e_rd));
        chk("outstanding", AW'(bus.o_outstanding), AW'(cnt));
        chk("err_order",   AW'(bus.o_err_order),   AW'(m_err));

        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (fl) begin
            m_run = 1'b1;
            m_pc  = fpc;
            foreach (q[i]) q[i].stale = 1'b1;
        end else if (e_rd) begin
            m_pc = npc;
            foreach (q[i]) q[i].stale = 1'b1;
        end else if (e_req && rdy) begin
            q.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 64'd4;
        end
        m_err = e_err;
        #1;
    endtask

    task automatic idle_step();
        step(0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic req_step();
        step(0, '0, 1, 0, 0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] fpc, ppc, npc, exp_next;
        bit            fl, rdy, pv, jmp;
        int            cnt;

        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state: everything reads zero.
        chk("rst_req_valid", AW'(bus.o_req_valid), '0);
        chk("rst_outstanding", AW'(bus.o_outstanding), '0);
        idle_step();

        // Flush to 0x1000, fill to QDEPTH, then requests stall.
        step(1, 64'h1000, 1, 0, 0, '0, '0);
        chk("first_addr", bus.o_req_addr, 64'h1000);
        repeat (5) req_step();
        chk("full_count", AW'(bus.o_outstanding), AW'(QD));
        // In-order responses without jumps; requests resume at 0x1010.
        for (int i = 0; i < 4; i++) step(0, '0, 1, 1, 0, 64'h1000 + 64'(4 * i), '0);
        req_step();

        // Predicted jump to 0x2000 with four outstanding.
        do_reset();
        step(1, 64'h1000, 1, 0, 0, '0, '0);
        repeat (4) req_step();
        step(0, '0, 1, 1, 1, 64'h1000, 64'h2000);
        chk("redir_addr", bus.o_req_addr, 64'h2000);
        for (int i = 1; i < 4; i++) step(0, '0, 1, 1, 0, 64'h1000 + 64'(4 * i), '0);
        step(0, '0, 1, 1, 0, 64'h2000, '0);

        // Jump whose target is already queued: no redirect.
        do_reset();
        step(1, 64'h1000, 1, 0, 0, '0, '0);
        repeat (2) req_step();
        step(0, '0, 0, 1, 1, 64'h1000, 64'h1004);
        step(0, '0, 1, 1, 0, 64'h1004, '0);

        // Flush with three outstanding and a same-cycle response.
        do_reset();
        step(1, 64'h1000, 1, 0, 0, '0, '0);
        repeat (3) req_step();
        step(1, 64'h8000, 1, 1, 0, 64'h1000, '0);
        chk("flush_addr", bus.o_req_addr, 64'h8000);
        step(0, '0, 1, 1, 0, 64'h1004, '0);
        step(0, '0, 1, 1, 0, 64'h1008, '0);
        step(0, '0, 1, 1, 0, 64'h8000, '0);

        // Out-of-order response pc: sticky error until reset.
        do_reset();
        step(1, 64'h1000, 1, 0, 0, '0, '0);
        req_step();
        step(0, '0, 0, 1, 0, 64'h1234, '0);
        repeat (3) idle_step();
        chk("err_sticky", AW'(bus.o_err_order), 64'd1);
        do_reset();
        chk("err_cleared", AW'(bus.o_err_order), 64'd0);
        // Response with nothing outstanding is ignored but flagged.
        step(0, '0, 0, 1, 0, 64'h40, '0);
        idle_step();

        // Randomized traffic, including address wrap and mid-run resets.
        do_reset();
        step(1, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, '0, '0);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 200) == 0) begin
                do_reset();
            end
            cnt = q.size();
            fl  = ($urandom_range(0, 24) == 0) || !m_run;
            fpc = {$urandom(), $urandom()} & ~64'h3;
            if ($urandom_range(0, 3) == 0) fpc = 64'hFFFF_FFFF_FFFF_FFF4;
            rdy = ($urandom_range(0, 3) != 0);
            pv  = (cnt > 0) && ($urandom_range(0, 1) == 1);
            ppc = (cnt > 0) ? q[0].addr : '0;
            jmp = ($urandom_range(0, 2) == 0);
            exp_next = (cnt >= 2) ? q[1].addr : m_pc;
            npc = ($urandom_range(0, 1) == 1) ? exp_next : ({$urandom(), $urandom()} & ~64'h3);
            step(fl, fpc, rdy, pv, jmp, ppc, npc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
